// File: rtl/kbd_mouse_bridge.sv
// Keyboard/mouse strobe consumer: per-mouse H/V/wheel counters,
// a keycode FIFO for the keyboard serialiser and OSD key events.
module kbd_mouse_bridge #(
    parameter int KBD_DEPTH = 8,
    parameter int INVERT_Y  = 0
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       kms_strobe,
    input  logic [1:0] kms_type,
    input  logic [7:0] kms_data,
    input  logic       mouse_idx,
    output logic [7:0] m0_hcnt,
    output logic [7:0] m0_vcnt,
    output logic [7:0] m0_wheel,
    output logic [7:0] m1_hcnt,
    output logic [7:0] m1_vcnt,
    output logic [7:0] m1_wheel,
    input  logic       kbd_rd,
    output logic [7:0] kbd_data,
    output logic       kbd_empty,
    output logic       kbd_overflow,
    input  logic       kbd_ovf_clr,
    output logic [7:0] osd_key,
    output logic       osd_key_valid
);

    localparam int AW = $clog2(KBD_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_Y = 2'd1,
        WAIT_W = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_x_en;
    logic       w_y_en;
    logic       w_w_en;
    logic       r_idx;
    logic [7:0] r_hcnt  [2];
    logic [7:0] r_vcnt  [2];
    logic [7:0] r_wheel [2];

    logic [7:0] r_mem [KBD_DEPTH];
    logic [AW:0] r_wp;
    logic [AW:0] r_rp;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_wr;
    logic        r_ovf;
    logic [7:0]  r_osd;
    logic        r_osd_v;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_x_en      = 1'b0;
        w_y_en      = 1'b0;
        w_w_en      = 1'b0;
        if (kms_strobe) begin
            unique case (kms_type)
                2'd0: begin
                    w_x_en      = 1'b1;
                    w_state_nxt = WAIT_Y;
                end
                2'd1: begin
                    if (r_state == WAIT_Y) begin
                        w_y_en      = 1'b1;
                        w_state_nxt = WAIT_W;
                    end else if (r_state == WAIT_W) begin
                        w_w_en      = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Y and wheel go to the mouse latched by the X strobe.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_idx <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_hcnt[i]  <= 8'h00;
                r_vcnt[i]  <= 8'h00;
                r_wheel[i] <= 8'h00;
            end
        end else begin
            if (w_x_en) begin
                r_idx <= mouse_idx;
                r_hcnt[mouse_idx] <= r_hcnt[mouse_idx] + kms_data;
            end
            if (w_y_en) begin
                if (INVERT_Y != 0)
                    r_vcnt[r_idx] <= r_vcnt[r_idx] - kms_data;
                else
                    r_vcnt[r_idx] <= r_vcnt[r_idx] + kms_data;
            end
            if (w_w_en)
                r_wheel[r_idx] <= r_wheel[r_idx] + kms_data;
        end
    end

    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                     (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_push  = kms_strobe && (kms_type == 2'd2);
    assign w_pop   = kbd_rd && !w_empty;
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge clk_sys) begin
        if (w_wr) r_mem[r_wp[AW-1:0]] <= kms_data;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_ovf   <= 1'b0;
            r_osd   <= 8'h00;
            r_osd_v <= 1'b0;
        end else begin
            if (w_wr)  r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            // A drop in the same cycle as a clear wins.
            if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
            else if (kbd_ovf_clr)           r_ovf <= 1'b0;
            r_osd_v <= kms_strobe && (kms_type == 2'd3);
            if (kms_strobe && (kms_type == 2'd3))
                r_osd <= kms_data;
        end
    end

    assign m0_hcnt       = r_hcnt[0];
    assign m0_vcnt       = r_vcnt[0];
    assign m0_wheel      = r_wheel[0];
    assign m1_hcnt       = r_hcnt[1];
    assign m1_vcnt       = r_vcnt[1];
    assign m1_wheel      = r_wheel[1];
    assign kbd_data      = r_mem[r_rp[AW-1:0]];
    assign kbd_empty     = w_empty;
    assign kbd_overflow  = r_ovf;
    assign osd_key       = r_osd;
    assign osd_key_valid = r_osd_v;

endmodule
